// File: rtl/iter_mul_unit_pkg.sv
// rtl/iter_mul_unit_pkg.sv - shared encodings and constants for the iterative multiplier
package iter_mul_unit_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [4:0] XZR_IDX    = 5'd31;
    localparam int         ITER_COUNT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/iter_mul_unit.sv
// rtl/iter_mul_unit.sv - radix-2 shift-add multiplier, fixed 65-cycle busy window
module iter_mul_unit
    import iter_mul_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [4:0]       RWIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RWOut,
    output logic             RegWr
);

    localparam logic [6:0] LAST_CNT = 7'(ITER_COUNT);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_negate(input logic [2*WIDTH-1:0] v,
                                                       input logic            en);
        return en ? ({(2*WIDTH){1'b0}} - v) : v;
    endfunction

    state_e               state_q, state_d;
    logic [6:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [4:0]           rw_q, rw_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   product;

    // Upper half of acc accumulates partial products; lower half holds the multiplier, shifted out LSB first.
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign product  = cond_negate(acc_q, neg_q);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            rw_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rw_q     <= rw_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rw_d     = rw_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    op_d    = Op;
                    rw_d    = RWIn;
                    if (Op == OP_SMULH) begin
                        mcand_d = magnitude(BusA);
                        acc_d   = {{WIDTH{1'b0}}, magnitude(BusB)};
                        neg_d   = BusA[WIDTH-1] ^ BusB[WIDTH-1];
                    end else begin
                        mcand_d = BusA;
                        acc_d   = {{WIDTH{1'b0}}, BusB};
                        neg_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != LAST_CNT) begin
                    acc_d = {step_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 7'd1;
                end else begin
                    // Extra cycle after the last step applies the sign fix and half select.
                    case (op_q)
                        OP_MUL:             result_d = product[WIDTH-1:0];
                        OP_UMULH, OP_SMULH: result_d = product[2*WIDTH-1:WIDTH];
                        default:            result_d = '0;
                    endcase
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy   = (state_q == ST_BUSY);
    assign Done   = (state_q == ST_DONE);
    assign Result = result_q;
    assign RWOut  = rw_q;
    assign RegWr  = Done && (rw_q != XZR_IDX);

endmodule

// File: tb/tb_iter_mul_unit.sv
// tb/tb_iter_mul_unit.sv - randomized self-checking bench for iter_mul_unit
module tb_iter_mul_unit;
    import iter_mul_unit_pkg::*;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [63:0] BusA = '0;
    logic [63:0] BusB = '0;
    logic [4:0]  RWIn = '0;
    logic        Busy, Done, RegWr;
    logic [63:0] Result;
    logic [4:0]  RWOut;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    iter_mul_unit #(.WIDTH(64)) dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start), .Op(Op),
        .BusA(BusA), .BusB(BusB), .RWIn(RWIn),
        .Busy(Busy), .Done(Done), .Result(Result), .RWOut(RWOut), .RegWr(RegWr)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0]        up;
        logic signed [127:0] sp;
        up = {64'd0, a} * {64'd0, b};
        sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        case (op)
            2'b00:   return up[63:0];
            2'b01:   return up[127:64];
            2'b10:   return sp[127:64];
            default: return 64'd0;
        endcase
    endfunction

    task automatic launch(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rw);
        Op = op; BusA = a; BusB = b; RWIn = rw; Start = 1'b1;
    endtask

    // Consumes edge k (Start sampled) and returns in the Done cycle; restart_n injects a stray Start.
    task automatic wait_done(input string tag, input int restart_n, output int n);
        bit busy_ok;
        busy_ok = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        n = 0;
        check({tag, " busy_at_k"}, 64'(Busy), 64'd1);
        while (!Done && n < 100) begin
            if (n == restart_n) begin
                Start = 1'b1; BusA = $urandom; BusB = $urandom; Op = OP_UMULH; RWIn = 5'd9;
            end
            @(posedge Clk); #1;
            n++;
            if (n == restart_n + 1) Start = 1'b0;
            if (!Done && !Busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(n), 64'd65);
        check({tag, " busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_in_done"}, 64'(Busy), 64'd0);
    endtask

    task automatic check_outputs(input string tag, input logic [63:0] exp, input logic [4:0] rw);
        check({tag, " result"}, Result, exp);
        check({tag, " rwout"}, 64'(RWOut), 64'(rw));
        check({tag, " regwr"}, 64'(RegWr), 64'(rw != 5'd31));
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rw, input int restart_n);
        logic [63:0] exp;
        int          n;
        exp = ref_result(op, a, b);
        launch(op, a, b, rw);
        wait_done(tag, restart_n, n);
        check_outputs(tag, exp, rw);
        @(posedge Clk); #1;
        check({tag, " done_pulse"}, 64'(Done), 64'd0);
        check({tag, " result_hold"}, Result, exp);
    endtask

    initial begin
        int          n, d1, d2;
        bit          saw_done;
        logic [63:0] a, b;
        logic [1:0]  op;
        logic [4:0]  rw;

        ResetN = 1'b0;
        launch(OP_MUL, 64'd3, 64'd3, 5'd1);
        repeat (3) @(posedge Clk);
        #1;
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset result", Result, 64'd0);
        check("reset rwout", 64'(RWOut), 64'd0);
        check("reset regwr", 64'(RegWr), 64'd0);
        Start = 1'b0;
        ResetN = 1'b1;
        @(posedge Clk); #1;
        check("idle busy", 64'(Busy), 64'd0);

        do_op("mul7x6", OP_MUL, 64'd7, 64'd6, 5'd3, -1);
        check("mul7x6 const", Result, 64'd42);
        do_op("umulh_ones", OP_UMULH, '1, '1, 5'd4, -1);
        check("umulh_ones const", Result, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("mul_ones", OP_MUL, '1, '1, 5'd5, -1);
        check("mul_ones const", Result, 64'd1);
        do_op("smulh_m1x5", OP_SMULH, '1, 64'd5, 5'd6, -1);
        check("smulh_m1x5 const", Result, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("smulh_min2", OP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7, -1);
        check("smulh_min2 const", Result, 64'h4000_0000_0000_0000);
        do_op("xzr", OP_MUL, 64'd2, 64'd3, 5'd31, -1);
        check("xzr const", Result, 64'd6);
        do_op("rsvd", OP_RSVD, 64'd1234, 64'd5678, 5'd8, -1);

        do_op("restart", OP_MUL, 64'd11, 64'd13, 5'd10, 9);
        saw_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge Clk); #1;
            if (Done) saw_done = 1'b1;
        end
        check("restart single_done", 64'(saw_done), 64'd0);

        launch(OP_UMULH, 64'hDEAD_BEEF_0123_4567, 64'hCAFE_F00D_89AB_CDEF, 5'd12);
        wait_done("b2b_first", -1, n);
        check_outputs("b2b_first", ref_result(OP_UMULH, 64'hDEAD_BEEF_0123_4567, 64'hCAFE_F00D_89AB_CDEF), 5'd12);
        d1 = cyc;
        launch(OP_SMULH, 64'hF000_0000_0000_0003, 64'h0123_4567_89AB_CDEF, 5'd13);
        wait_done("b2b_second", -1, n);
        check_outputs("b2b_second", ref_result(OP_SMULH, 64'hF000_0000_0000_0003, 64'h0123_4567_89AB_CDEF), 5'd13);
        d2 = cyc;
        check("b2b spacing", 64'(d2 - d1), 64'd66);

        launch(OP_MUL, 64'd5, 64'd9, 5'd4);
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (29) @(posedge Clk);
        #1;
        ResetN = 1'b0;
        @(posedge Clk); #1;
        check("abort busy", 64'(Busy), 64'd0);
        check("abort done", 64'(Done), 64'd0);
        check("abort result", Result, 64'd0);
        check("abort regwr", 64'(RegWr), 64'd0);
        ResetN = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk); #1;
            if (Done) saw_done = 1'b1;
        end
        check("abort no_done", 64'(saw_done), 64'd0);

        for (int t = 0; t < 24; t++) begin
            op = 2'($urandom_range(0, 3));
            rw = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: a = {$urandom, $urandom};
                1: a = 64'h8000_0000_0000_0000;
                2: a = '1;
                default: a = 64'($urandom_range(0, 100));
            endcase
            case ($urandom_range(0, 3))
                0: b = {$urandom, $urandom};
                1: b = 64'h8000_0000_0000_0000;
                2: b = '1;
                default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            do_op($sformatf("rand%0d", t), op, a, b, rw, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
